wb_stage: RTL and testbench

Writeback stage of the NPC core, directly upstream of the register file's write port. Accepts one completed instruction per handshake from execute/memory, waits for memory response data on loads, and formats that data (byte-lane extraction and sign/zero extension). Drives a single-cycle registered write into the register file and exports a pending-destination indication for decode interlock.

---
 rtl/wb_stage.sv | 137 +++++++++++++
 tb/tb_wb_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: writeback stage. Retires ALU results, waits for load data, and formats it.
// Ports: in_* from EX/MEM, mem_r* load data, rf_* RF write, pend_* interlock, retire_cnt (WB_RETIRE_CNT_EN).
module wb_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_wen,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  commit_valid,
  output logic                  pend_valid,
  output logic [ADDR_WIDTH-1:0] pend_rd,
  output logic [63:0]           retire_cnt
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t                st, st_n;
  logic [ADDR_WIDTH-1:0] ld_rd;
  logic                  ld_wen;
  logic [2:0]            ld_f3;
  logic [2:0]            ld_off;
  logic                  cap;
  logic                  cm_n;
  logic                  wen_n;
  logic [ADDR_WIDTH-1:0] waddr_n;
  logic [DATA_WIDTH-1:0] wdata_n;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [7:0]            b;
  logic [15:0]           h;
  logic [31:0]           w;

  // Lane select drops misaligned low offset bits.
  always_comb begin
    b = mem_rdata[{ld_off, 3'b000} +: 8];
    h = mem_rdata[{ld_off[2:1], 4'b0000} +: 16];
    w = mem_rdata[{ld_off[2], 5'b00000} +: 32];
    ld_data = '0;
    case (ld_f3)
      3'b000:  ld_data = {{56{b[7]}}, b};
      3'b001:  ld_data = {{48{h[15]}}, h};
      3'b010:  ld_data = {{32{w[31]}}, w};
      3'b011:  ld_data = mem_rdata;
      3'b100:  ld_data = {56'd0, b};
      3'b101:  ld_data = {48'd0, h};
      3'b110:  ld_data = {32'd0, w};
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    st_n    = st;
    cap     = 1'b0;
    cm_n    = 1'b0;
    wen_n   = 1'b0;
    waddr_n = '0;
    wdata_n = '0;
    unique case (st)
      IDLE: begin
        if (in_valid) begin
          if (in_is_load) begin
            cap  = 1'b1;
            st_n = WAIT_MEM;
          end else begin
            cm_n    = 1'b1;
            wen_n   = in_wen && (in_rd != '0);
            waddr_n = in_rd;
            wdata_n = in_result;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          cm_n    = 1'b1;
          wen_n   = ld_wen && (ld_rd != '0);
          waddr_n = ld_rd;
          wdata_n = ld_data;
          st_n    = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= IDLE;
      ld_rd        <= '0;
      ld_wen       <= 1'b0;
      ld_f3        <= '0;
      ld_off       <= '0;
      commit_valid <= 1'b0;
      rf_wen       <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
    end else begin
      st           <= st_n;
      commit_valid <= cm_n;
      rf_wen       <= wen_n;
      rf_waddr     <= waddr_n;
      rf_wdata     <= wdata_n;
      if (cap) begin
        ld_rd  <= in_rd;
        ld_wen <= in_wen;
        ld_f3  <= in_funct3;
        ld_off <= in_result[2:0];
      end
    end
  end

  assign in_ready   = (st == IDLE);
  assign pend_valid = (st == WAIT_MEM) && ld_wen && (ld_rd != '0);
  assign pend_rd    = pend_valid ? ld_rd : '0;

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      retire_cnt <= '0;
    else if (commit_valid)
      retire_cnt <= retire_cnt + 64'd1;
  end
`else
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: self-checking bench for wb_stage.
// Reference model checked every cycle plus literal directed expectations.
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic        in_wen = 1'b0;
  logic [63:0] in_result = '0;
  logic        in_is_load = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        commit_valid;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic [63:0] retire_cnt;

  int checks = 0;
  int errors = 0;

  wb_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_wen(in_wen), .in_result(in_result),
    .in_is_load(in_is_load), .in_funct3(in_funct3),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .commit_valid(commit_valid),
    .pend_valid(pend_valid), .pend_rd(pend_rd),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  // Load result from access size and extension rules.
  function automatic logic [63:0] fmt(logic [2:0] f3, logic [2:0] off,
                                      logic [63:0] word);
    int sz;
    int a;
    logic [63:0] v;
    logic [63:0] m;
    if (f3 == 3'b111) return 64'd0;
    sz = 1 << f3[1:0];
    a  = (int'(off) / sz) * sz;
    v  = word >> (8 * a);
    if (sz < 8) begin
      m = (64'd1 << (8 * sz)) - 64'd1;
      v = v & m;
      if (!f3[2] && v[8*sz-1]) v = v | ~m;
    end
    return v;
  endfunction

  logic        m_busy;
  logic [4:0]  m_rd;
  logic        m_wen;
  logic [2:0]  m_f3;
  logic [2:0]  m_off;
  logic        e_cv;
  logic        e_wen;
  logic [4:0]  e_waddr;
  logic [63:0] e_wdata;
  logic [63:0] m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_rd <= '0; m_wen <= 1'b0;
      m_f3 <= '0; m_off <= '0;
      e_cv <= 1'b0; e_wen <= 1'b0; e_waddr <= '0; e_wdata <= '0;
      m_cnt <= '0;
    end else begin
      e_cv <= 1'b0; e_wen <= 1'b0; e_waddr <= '0; e_wdata <= '0;
      if (e_cv) m_cnt <= m_cnt + 64'd1;
      if (!m_busy) begin
        if (in_valid && in_is_load) begin
          m_busy <= 1'b1; m_rd <= in_rd; m_wen <= in_wen;
          m_f3 <= in_funct3; m_off <= in_result[2:0];
        end else if (in_valid) begin
          e_cv <= 1'b1; e_wen <= in_wen && in_rd != 0;
          e_waddr <= in_rd; e_wdata <= in_result;
        end
      end else if (mem_rvalid) begin
        m_busy <= 1'b0;
        e_cv <= 1'b1; e_wen <= m_wen && m_rd != 0;
        e_waddr <= m_rd; e_wdata <= fmt(m_f3, m_off, mem_rdata);
      end
    end
  end

  logic [63:0] e_cnt;
`ifdef WB_RETIRE_CNT_EN
  assign e_cnt = m_cnt;
`else
  assign e_cnt = 64'd0;
`endif

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_commit_valid", commit_valid, e_cv);
      chk("m_rf_wen", rf_wen, e_wen);
      chk("m_rf_waddr", rf_waddr, e_waddr);
      chk("m_rf_wdata", rf_wdata, e_wdata);
      chk("m_in_ready", in_ready, !m_busy);
      chk("m_pend_valid", pend_valid, m_busy && m_wen && m_rd != 0);
      chk("m_pend_rd", pend_rd,
          (m_busy && m_wen && m_rd != 0) ? m_rd : 5'd0);
      chk("m_retire_cnt", retire_cnt, e_cnt);
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic idle;
    in_valid = 1'b0; in_is_load = 1'b0;
    in_rd = '0; in_wen = 1'b0; in_result = '0; in_funct3 = '0;
  endtask

  task automatic alu(logic [4:0] rd, logic wen, logic [63:0] res);
    in_valid = 1'b1; in_is_load = 1'b0;
    in_rd = rd; in_wen = wen; in_result = res;
  endtask

  task automatic chk_rst_vals;
    chk("rst_rf_wen", rf_wen, 1'b0);
    chk("rst_rf_waddr", rf_waddr, 5'd0);
    chk("rst_rf_wdata", rf_wdata, 64'd0);
    chk("rst_commit", commit_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_pend_valid", pend_valid, 1'b0);
    chk("rst_pend_rd", pend_rd, 5'd0);
    chk("rst_retire_cnt", retire_cnt, 64'd0);
  endtask

  // Returns in the commit cycle of the load, inputs idle.
  task automatic do_load(logic [4:0] rd, logic [2:0] f3, logic [63:0] addr,
                         logic [63:0] data, int dly, logic early);
    in_valid = 1'b1; in_is_load = 1'b1; in_wen = 1'b1;
    in_rd = rd; in_funct3 = f3; in_result = addr;
    mem_rvalid = early; mem_rdata = ~data;
    tick;
    idle;
    mem_rvalid = 1'b0;
    for (int i = 0; i < dly; i++) begin
      chk("wait_in_ready", in_ready, 1'b0);
      chk("wait_pend_valid", pend_valid, rd != 0);
      chk("wait_pend_rd", pend_rd, rd);
      tick;
    end
    mem_rvalid = 1'b1; mem_rdata = data;
    tick;
    mem_rvalid = 1'b0;
    chk("ld_commit", commit_valid, 1'b1);
    chk("ld_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    #1;
    chk_rst_vals;
    tick; tick;
    rst = 1'b0;

    alu(5'd5, 1'b1, 64'h1234);
    tick;
    idle;
    chk("alu_wen", rf_wen, 1'b1);
    chk("alu_waddr", rf_waddr, 5'd5);
    chk("alu_wdata", rf_wdata, 64'h1234);
    chk("alu_commit", commit_valid, 1'b1);
    tick;
    chk("alu_wen_drop", rf_wen, 1'b0);

    alu(5'd0, 1'b1, 64'h77);
    tick;
    idle;
    chk("rd0_wen", rf_wen, 1'b0);
    chk("rd0_commit", commit_valid, 1'b1);
    tick;

    do_load(5'd7, 3'b000, 64'h1003, 64'h00000000_80FF0000, 3, 1'b0);
    chk("lb_data", rf_wdata, 64'hFFFFFFFF_FFFFFF80);
    chk("lb_waddr", rf_waddr, 5'd7);
    do_load(5'd9, 3'b110, 64'h2004, 64'h89ABCDEF_01234567, 1, 1'b1);
    chk("lwu_data", rf_wdata, 64'h00000000_89ABCDEF);
    do_load(5'd10, 3'b011, 64'h2000, 64'h89ABCDEF_01234567, 2, 1'b0);
    chk("ld_data", rf_wdata, 64'h89ABCDEF_01234567);
    do_load(5'd11, 3'b111, 64'h2000, 64'h89ABCDEF_01234567, 1, 1'b0);
    chk("f7_data", rf_wdata, 64'd0);
    do_load(5'd0, 3'b001, 64'h2007, 64'h89ABCDEF_01234567, 1, 1'b0);
    chk("lh_data", rf_wdata, 64'hFFFFFFFF_FFFF89AB);
    chk("lh_rd0_wen", rf_wen, 1'b0);
    tick;

    in_valid = 1'b1; in_is_load = 1'b1; in_wen = 1'b1;
    in_rd = 5'd12; in_funct3 = 3'b011; in_result = 64'h3000;
    tick;
    idle;
    tick;
    rst = 1'b1;
    #1;
    chk_rst_vals;
    tick;
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF;
    tick;
    mem_rvalid = 1'b0;
    chk("late_rvalid_wen", rf_wen, 1'b0);
    chk("late_rvalid_commit", commit_valid, 1'b0);

    for (int i = 0; i < 4; i++) begin
      alu(5'(i + 1), 1'b1, 64'(i * 'h111 + 1));
      tick;
      chk("b2b_commit", commit_valid, 1'b1);
    end
    in_valid = 1'b1; in_is_load = 1'b1; in_wen = 1'b1;
    in_rd = 5'd20; in_funct3 = 3'b100; in_result = 64'h4001;
    tick;
    idle;
    tick;
    mem_rvalid = 1'b1; mem_rdata = 64'h00000000_0000AB00;
    tick;
    mem_rvalid = 1'b0;
    alu(5'd21, 1'b1, 64'h55);
    chk("lbu_data", rf_wdata, 64'hAB);
    chk("lbu_ready", in_ready, 1'b1);
    tick;
    idle;
    chk("nobubble_commit", commit_valid, 1'b1);
    chk("nobubble_waddr", rf_waddr, 5'd21);
    chk("nobubble_wdata", rf_wdata, 64'h55);
    tick;
`ifdef WB_RETIRE_CNT_EN
    chk("retire_6", retire_cnt, 64'd6);
`else
    chk("retire_tied", retire_cnt, 64'd0);
`endif
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
